countdown_timer_core: RTL

Parametrised MM:SS timer core: the successor to the fixed minutes-counter/state-machine pair. It combines preset entry, up or down counting, pause/resume and an end-of-count alarm in one block. It sits between the button debouncer (its inputs are debounced single-cycle pulses) and the VGA painter, which consumes the four BCD digits and the state code.

---
 rtl/timer_pkg.sv | 50 +++++
 rtl/tick_prescaler.sv | 43 ++++
 rtl/countdown_timer_core.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the MM:SS timer core.
//   - State codes driven on the core's 3-bit state output.
//   - Single-digit BCD increment/decrement helpers with carry/borrow out.
//   - Prescaler counter width derived from the clock divide ratio.
package timer_pkg;

  // State codes; codes 5..7 are unused and recover to StIdle.
  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSet   = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StPause = 3'd3;
  localparam logic [2:0] StDone  = 3'd4;

  typedef struct packed {
    logic       carry;
    logic [3:0] digit;
  } bcd_step_t;

  // Digit + 1, wrapping top -> 0 with carry out.
  function automatic bcd_step_t bcd_inc(input logic [3:0] d, input logic [3:0] top);
    bcd_step_t r;
    if (d >= top) begin
      r.carry = 1'b1;
      r.digit = 4'd0;
    end else begin
      r.carry = 1'b0;
      r.digit = d + 4'd1;
    end
    return r;
  endfunction

  // Digit - 1, wrapping 0 -> top with borrow out.
  function automatic bcd_step_t bcd_dec(input logic [3:0] d, input logic [3:0] top);
    bcd_step_t r;
    if (d == 4'd0) begin
      r.carry = 1'b1;
      r.digit = top;
    end else begin
      r.carry = 1'b0;
      r.digit = d - 4'd1;
    end
    return r;
  endfunction

  // Bits needed to count 0..div-1.
  function automatic int unsigned presc_width(input int unsigned div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler.
//   CLK_50MHZ : system clock
//   reset     : asynchronous active-low reset
//   clr       : synchronous clear of the count (restarts a full period)
//   en        : count enable; the count holds while low
//   tick      : high for the one cycle in which the count wraps
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic CLK_50MHZ,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = presc_width(DIV);
  localparam logic [W-1:0] Last = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer_core.sv
// MM:SS timer core: preset entry, up/down counting, pause/resume and end-of-count alarm.
//   CLK_50MHZ, reset (async, active-low)
//   start/stop/clear/inc_sec/inc_min : single-cycle debounced event pulses
//   count_down : 1 = count down, 0 = count up; latched on an accepted start
//   m_dec, m_unit, s_dec, s_unit : registered BCD digits
//   state : current state code, running : in RUN
//   done  : one-cycle pulse on entry to DONE
//   alarm : high for ALARM_CYCLES cycles starting with entry to DONE
module countdown_timer_core
  import timer_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50_000_000,
  parameter int unsigned TICK_HZ      = 1,
  parameter int unsigned MAX_MINUTES  = 99,
  parameter int unsigned ALARM_CYCLES = 50_000_000
) (
  input  logic       CLK_50MHZ,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       count_down,
  output logic [3:0] m_dec,
  output logic [3:0] m_unit,
  output logic [3:0] s_dec,
  output logic [3:0] s_unit,
  output logic [2:0] state,
  output logic       running,
  output logic       done,
  output logic       alarm
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam logic [3:0] MaxMDec  = 4'(MAX_MINUTES / 10);
  localparam logic [3:0] MaxMUnit = 4'(MAX_MINUTES % 10);
  localparam int unsigned AW = (ALARM_CYCLES > 1) ? $clog2(ALARM_CYCLES) : 1;
  localparam logic [AW-1:0] AlarmLoad = AW'(ALARM_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic          mode_q, mode_d;
  logic [3:0]    m_dec_q, m_dec_d, m_unit_q, m_unit_d;
  logic [3:0]    s_dec_q, s_dec_d, s_unit_q, s_unit_d;
  logic          running_q, done_q;
  logic          alarm_q, alarm_d;
  logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
  logic          presc_clr, tick;

  // Only the highest-priority asserted event is seen by the FSM.
  logic ev_clear, ev_stop, ev_start, ev_inc_min, ev_inc_sec;
  assign ev_clear   = clear;
  assign ev_stop    = stop & ~clear;
  assign ev_start   = start & ~clear & ~stop;
  assign ev_inc_min = inc_min & ~clear & ~stop & ~start;
  assign ev_inc_sec = inc_sec & ~clear & ~stop & ~start & ~inc_min;

  logic is_zero, min_at_max, sec_at_59;
  assign is_zero    = (m_dec_q == 4'd0) && (m_unit_q == 4'd0) &&
                      (s_dec_q == 4'd0) && (s_unit_q == 4'd0);
  assign min_at_max = (m_dec_q == MaxMDec) && (m_unit_q == MaxMUnit);
  assign sec_at_59  = (s_dec_q == 4'd5) && (s_unit_q == 4'd9);

  bcd_step_t su_inc, sd_inc, mu_inc, su_dec, sd_dec, mu_dec;

  tick_prescaler #(
    .DIV(DIV)
  ) u_prescaler (
    .CLK_50MHZ(CLK_50MHZ),
    .reset    (reset),
    .clr      (presc_clr),
    .en       (state_q == StRun),
    .tick     (tick)
  );

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    m_dec_d   = m_dec_q;
    m_unit_d  = m_unit_q;
    s_dec_d   = s_dec_q;
    s_unit_d  = s_unit_q;
    presc_clr = 1'b0;

    su_inc = bcd_inc(s_unit_q, 4'd9);
    sd_inc = bcd_inc(s_dec_q, 4'd5);
    mu_inc = bcd_inc(m_unit_q, 4'd9);
    su_dec = bcd_dec(s_unit_q, 4'd9);
    sd_dec = bcd_dec(s_dec_q, 4'd5);
    mu_dec = bcd_dec(m_unit_q, 4'd9);

    if (ev_clear) begin
      state_d   = StIdle;
      m_dec_d   = 4'd0;
      m_unit_d  = 4'd0;
      s_dec_d   = 4'd0;
      s_unit_d  = 4'd0;
      presc_clr = 1'b1;
    end else begin
      case (state_q)
        StIdle, StSet, StPause: begin
          if (ev_start) begin
            // Counting down from 00:00 would end immediately; refuse it.
            if (!(count_down && is_zero)) begin
              mode_d    = count_down;
              presc_clr = 1'b1;
              state_d   = StRun;
            end
          end else if (ev_inc_min) begin
            state_d = StSet;
            if (min_at_max) begin
              m_dec_d  = 4'd0;
              m_unit_d = 4'd0;
            end else begin
              m_unit_d = mu_inc.digit;
              if (mu_inc.carry) m_dec_d = bcd_inc(m_dec_q, 4'd9).digit;
            end
          end else if (ev_inc_sec) begin
            // Preset seconds wrap 59 -> 00 without touching minutes.
            state_d  = StSet;
            s_unit_d = su_inc.digit;
            if (su_inc.carry) s_dec_d = sd_inc.digit;
          end
        end
        StRun: begin
          if (ev_stop) begin
            state_d   = StPause;
            presc_clr = 1'b1;
          end else if (tick) begin
            if (!mode_q) begin
              if (min_at_max && sec_at_59) begin
                state_d = StDone;
              end else begin
                s_unit_d = su_inc.digit;
                if (su_inc.carry) begin
                  s_dec_d = sd_inc.digit;
                  if (sd_inc.carry) begin
                    m_unit_d = mu_inc.digit;
                    if (mu_inc.carry) m_dec_d = bcd_inc(m_dec_q, 4'd9).digit;
                  end
                end
              end
            end else begin
              s_unit_d = su_dec.digit;
              if (su_dec.carry) begin
                s_dec_d = sd_dec.digit;
                if (sd_dec.carry) begin
                  m_unit_d = mu_dec.digit;
                  if (mu_dec.carry) m_dec_d = bcd_dec(m_dec_q, 4'd9).digit;
                end
              end
              if ((m_dec_d == 4'd0) && (m_unit_d == 4'd0) &&
                  (s_dec_d == 4'd0) && (s_unit_d == 4'd0)) begin
                state_d = StDone;
              end
            end
          end
        end
        StDone: begin
          // Value frozen; only clear leaves DONE.
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Alarm: loaded on entry to DONE, then counts down to drop after ALARM_CYCLES cycles.
  always_comb begin
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    if (ev_clear) begin
      alarm_d     = 1'b0;
      alarm_cnt_d = '0;
    end else if ((state_d == StDone) && (state_q != StDone)) begin
      alarm_d     = 1'b1;
      alarm_cnt_d = AlarmLoad;
    end else if (alarm_q) begin
      if (alarm_cnt_q == '0) begin
        alarm_d = 1'b0;
      end else begin
        alarm_cnt_d = alarm_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50MHZ or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      mode_q      <= 1'b0;
      m_dec_q     <= 4'd0;
      m_unit_q    <= 4'd0;
      s_dec_q     <= 4'd0;
      s_unit_q    <= 4'd0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      m_dec_q     <= m_dec_d;
      m_unit_q    <= m_unit_d;
      s_dec_q     <= s_dec_d;
      s_unit_q    <= s_unit_d;
      running_q   <= (state_d == StRun);
      done_q      <= (state_d == StDone) && (state_q != StDone);
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign m_dec   = m_dec_q;
  assign m_unit  = m_unit_q;
  assign s_dec   = s_dec_q;
  assign s_unit  = s_unit_q;
  assign state   = state_q;
  assign running = running_q;
  assign done    = done_q;
  assign alarm   = alarm_q;

endmodule
